// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - ALU operator encoding shared by the branch ALU arbiter
package ibex_pkg;

  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4,
    ALU_LT  = 7'd5,
    ALU_LTU = 7'd6,
    ALU_GE  = 7'd7,
    ALU_GEU = 7'd8,
    ALU_EQ  = 7'd9,
    ALU_NE  = 7'd10
  } alu_op_e;

endpackage

// File: rtl/ibex_branch_alu_arbiter_if.sv
// rtl/ibex_branch_alu_arbiter_if.sv - request/response/ALU signals of the branch ALU arbiter
interface ibex_branch_alu_arbiter_if;
  import ibex_pkg::*;

  logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  alu_op_e     req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;

  logic        resp0_valid_o, resp0_ready_i, resp0_cmp_o;
  logic        resp1_valid_o, resp1_ready_i, resp1_cmp_o;
  logic [31:0] resp0_target_o, resp1_target_o;

  alu_op_e     alu_operator_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_adder_result_i;
  logic        alu_cmp_result_i;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req0_ready_o, req1_ready_o,
    output resp0_valid_o, resp0_target_o, resp0_cmp_o,
    output resp1_valid_o, resp1_target_o, resp1_cmp_o,
    input  resp0_ready_i, resp1_ready_i,
    output alu_operator_o, alu_operand_a_o, alu_operand_b_o,
    input  alu_adder_result_i, alu_cmp_result_i
  );

  // Requesters, consumers and shared ALU side
  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req0_ready_o, req1_ready_o,
    input  resp0_valid_o, resp0_target_o, resp0_cmp_o,
    input  resp1_valid_o, resp1_target_o, resp1_cmp_o,
    output resp0_ready_i, resp1_ready_i,
    input  alu_operator_o, alu_operand_a_o, alu_operand_b_o,
    output alu_adder_result_i, alu_cmp_result_i
  );

endinterface

// File: rtl/ibex_branch_alu_arbiter.sv
// rtl/ibex_branch_alu_arbiter.sv - two-requester arbiter in front of a shared branch ALU
module ibex_branch_alu_arbiter
  import ibex_pkg::*;
#(
  parameter bit RoundRobin = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  ibex_branch_alu_arbiter_if.slave  bus,
  output logic                      busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, owner_q;
  alu_op_e     op_q;
  logic [31:0] a_q, b_q, target_q;
  logic        cmp_q;
  logic        grant, can_accept, accept, owner_ready;

  always_comb begin
    grant = bus.req1_valid_i;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant = RoundRobin ? ~last_grant_q : 1'b0;
    end
  end

  // Reset is folded in so nothing is offered while the async reset is held
  assign can_accept       = (state_q == IDLE) && !flush_i && !rst_i;
  assign bus.req0_ready_o = can_accept && bus.req0_valid_i && (grant == 1'b0);
  assign bus.req1_ready_o = can_accept && bus.req1_valid_i && (grant == 1'b1);
  assign accept           = bus.req0_ready_o || bus.req1_ready_o;
  assign owner_ready      = owner_q ? bus.resp1_ready_i : bus.resp0_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= ALU_ADD;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      cmp_q        <= 1'b0;
      target_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant;
        owner_q      <= grant;
        op_q         <= grant ? bus.req1_op_i : bus.req0_op_i;
        a_q          <= grant ? bus.req1_a_i  : bus.req0_a_i;
        b_q          <= grant ? bus.req1_b_i  : bus.req0_b_i;
      end
      if (state_q == EXEC && !flush_i) cmp_q    <= bus.alu_cmp_result_i;
      if (state_q == WAIT && !flush_i) target_q <= bus.alu_adder_result_i;
    end
  end

  assign bus.alu_operator_o  = op_q;
  assign bus.alu_operand_a_o = a_q;
  assign bus.alu_operand_b_o = b_q;

  // A flush in RESP withdraws the response so a same-cycle ready is not a handshake
  assign bus.resp0_valid_o  = (state_q == RESP) && !owner_q && !flush_i;
  assign bus.resp1_valid_o  = (state_q == RESP) &&  owner_q && !flush_i;
  assign bus.resp0_target_o = target_q;
  assign bus.resp1_target_o = target_q;
  assign bus.resp0_cmp_o    = cmp_q;
  assign bus.resp1_cmp_o    = cmp_q;

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_branch_alu_arbiter.sv
// tb/tb_ibex_branch_alu_arbiter.sv - directed bench for the branch ALU arbiter (both grant modes)
module tb_ibex_branch_alu_arbiter;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        v0, v1, rr0, rr1;
  alu_op_e     op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        busy_u, busy_f;
  logic [31:0] add_u, add_f;
  int          checks = 0;
  int          failures = 0;

  ibex_branch_alu_arbiter_if u_if ();
  ibex_branch_alu_arbiter_if f_if ();

  ibex_branch_alu_arbiter #(.RoundRobin(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(u_if.slave), .busy_o(busy_u));
  ibex_branch_alu_arbiter #(.RoundRobin(1'b0)) f_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(f_if.slave), .busy_o(busy_f));

  always #5 clk = ~clk;

  function automatic logic cmp_model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_EQ:  return a == b;
      ALU_NE:  return a != b;
      ALU_LT:  return $signed(a) < $signed(b);
      ALU_LTU: return a < b;
      ALU_GE:  return $signed(a) >= $signed(b);
      ALU_GEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign u_if.req0_valid_i = v0;  assign f_if.req0_valid_i = v0;
  assign u_if.req1_valid_i = v1;  assign f_if.req1_valid_i = v1;
  assign u_if.req0_op_i = op0;    assign f_if.req0_op_i = op0;
  assign u_if.req1_op_i = op1;    assign f_if.req1_op_i = op1;
  assign u_if.req0_a_i = a0;      assign f_if.req0_a_i = a0;
  assign u_if.req0_b_i = b0;      assign f_if.req0_b_i = b0;
  assign u_if.req1_a_i = a1;      assign f_if.req1_a_i = a1;
  assign u_if.req1_b_i = b1;      assign f_if.req1_b_i = b1;
  assign u_if.resp0_ready_i = rr0; assign f_if.resp0_ready_i = rr0;
  assign u_if.resp1_ready_i = rr1; assign f_if.resp1_ready_i = rr1;

  // Shared ALU models: registered adder, combinational comparator
  always_ff @(posedge clk) begin
    add_u <= u_if.alu_operand_a_o + u_if.alu_operand_b_o;
    add_f <= f_if.alu_operand_a_o + f_if.alu_operand_b_o;
  end
  assign u_if.alu_adder_result_i = add_u;
  assign f_if.alu_adder_result_i = add_f;
  assign u_if.alu_cmp_result_i = cmp_model(u_if.alu_operator_o, u_if.alu_operand_a_o, u_if.alu_operand_b_o);
  assign f_if.alu_cmp_result_i = cmp_model(f_if.alu_operator_o, f_if.alu_operand_a_o, f_if.alu_operand_b_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    v0 = 1'b1; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    op0 = ALU_ADD; op1 = ALU_ADD; a0 = 0; b0 = 0; a1 = 0; b1 = 0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready0", u_if.req0_ready_o, 0);
    chk("rst_busy", busy_u, 0);
    chk("rst_resp0_valid", u_if.resp0_valid_o, 0);
    chk("rst_operator", u_if.alu_operator_o, ALU_ADD);
    chk("rst_operand_a", u_if.alu_operand_a_o, 0);
    chk("rst_target", u_if.resp0_target_o, 0);
    chk("rst_cmp", u_if.resp1_cmp_o, 0);

    // Single requester, handshake in first cycle out of reset
    @(negedge clk);
    rst = 1'b0; v0 = 1'b1; op0 = ALU_EQ; a0 = 32'h10; b0 = 32'h10; rr0 = 1'b1;
    #1;
    chk("single_ready0", u_if.req0_ready_o, 1);
    chk("single_ready1", u_if.req1_ready_o, 0);
    @(negedge clk); v0 = 1'b0; #1;
    chk("single_exec_busy", busy_u, 1);
    chk("single_exec_opa", u_if.alu_operand_a_o, 32'h10);
    chk("single_exec_valid", u_if.resp0_valid_o, 0);
    @(negedge clk); #1;
    chk("single_wait_valid", u_if.resp0_valid_o, 0);
    @(negedge clk); #1;
    chk("single_resp_valid0", u_if.resp0_valid_o, 1);
    chk("single_resp_valid1", u_if.resp1_valid_o, 0);
    chk("single_resp_cmp", u_if.resp0_cmp_o, 1);
    chk("single_resp_target", u_if.resp0_target_o, 32'h20);
    @(negedge clk); #1;
    chk("single_idle_busy", busy_u, 0);
    chk("single_idle_valid", u_if.resp0_valid_o, 0);

    // Ties from fresh reset: alternate for round-robin, always 0 for fixed
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; op0 = ALU_ADD; op1 = ALU_ADD;
    a0 = 32'd10; b0 = 32'd1; a1 = 32'd20; b1 = 32'd2; rr0 = 1'b1; rr1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_rr_ready0", u_if.req0_ready_o, (i % 2) == 0);
      chk("tie_rr_ready1", u_if.req1_ready_o, (i % 2) == 1);
      chk("tie_fix_ready0", f_if.req0_ready_o, 1);
      chk("tie_fix_ready1", f_if.req1_ready_o, 0);
      @(negedge clk); @(negedge clk); @(negedge clk); #1;
      chk("tie_rr_resp0", u_if.resp0_valid_o, (i % 2) == 0);
      chk("tie_rr_resp1", u_if.resp1_valid_o, (i % 2) == 1);
      chk("tie_rr_target", u_if.resp0_target_o, ((i % 2) == 0) ? 32'd11 : 32'd22);
      chk("tie_fix_resp0", f_if.resp0_valid_o, 1);
      chk("tie_fix_target", f_if.resp0_target_o, 32'd11);
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0;

    // Backpressure on requester 1
    op1 = ALU_LT; a1 = 32'd5; b1 = 32'd3; rr1 = 1'b0; v1 = 1'b1; #1;
    chk("bp_ready1", u_if.req1_ready_o, 1);
    @(negedge clk); v1 = 1'b0; v0 = 1'b1; #1;
    chk("bp_exec_ready0", u_if.req0_ready_o, 0);
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid1", u_if.resp1_valid_o, 1);
      chk("bp_hold_valid0", u_if.resp0_valid_o, 0);
      chk("bp_hold_target", u_if.resp1_target_o, 32'd8);
      chk("bp_hold_cmp", u_if.resp1_cmp_o, 0);
      chk("bp_hold_ready0", u_if.req0_ready_o, 0);
      chk("bp_hold_ready1", u_if.req1_ready_o, 0);
      @(negedge clk);
    end
    v0 = 1'b0; rr1 = 1'b1; #1;
    chk("bp_release_valid1", u_if.resp1_valid_o, 1);
    @(negedge clk); #1;
    chk("bp_release_busy", busy_u, 0);
    chk("bp_release_valid1_low", u_if.resp1_valid_o, 0);

    // Flush during WAIT
    v1 = 1'b1; op1 = ALU_LTU; a1 = 32'd1; b1 = 32'd2; #1;
    chk("fl_ready1", u_if.req1_ready_o, 1);
    @(negedge clk); v1 = 1'b0;
    @(negedge clk); flush = 1'b1; #1;
    chk("fl_wait_busy", busy_u, 1);
    @(negedge clk); flush = 1'b0; #1;
    chk("fl_after_busy", busy_u, 0);
    chk("fl_after_valid1", u_if.resp1_valid_o, 0);
    chk("fl_after_cmp", u_if.resp1_cmp_o, 1);
    chk("fl_after_target", u_if.resp1_target_o, 32'd8);
    @(negedge clk); #1;
    chk("fl_later_valid1", u_if.resp1_valid_o, 0);
    chk("fl_later_busy", busy_u, 0);

    // Flush in IDLE blocks the grant
    v0 = 1'b1; op0 = ALU_ADD; flush = 1'b1; #1;
    chk("fl_idle_ready0", u_if.req0_ready_o, 0);
    @(negedge clk); flush = 1'b0; v0 = 1'b0; #1;
    chk("fl_idle_busy", busy_u, 0);

    // 32-bit wrap-around
    v0 = 1'b1; op0 = ALU_GEU; a0 = 32'hFFFF_FFFF; b0 = 32'd1; rr0 = 1'b1; #1;
    chk("wrap_ready0", u_if.req0_ready_o, 1);
    @(negedge clk); v0 = 1'b0; #1;
    chk("wrap_operator", u_if.alu_operator_o, ALU_GEU);
    chk("wrap_operand_b", u_if.alu_operand_b_o, 32'd1);
    @(negedge clk); @(negedge clk); #1;
    chk("wrap_valid0", u_if.resp0_valid_o, 1);
    chk("wrap_target", u_if.resp0_target_o, 32'h0000_0000);
    chk("wrap_cmp", u_if.resp0_cmp_o, 1);
    @(negedge clk);

    // Operator outside the comparison set passes straight through
    v0 = 1'b1; op0 = alu_op_e'(7'h5a); a0 = 32'd3; b0 = 32'd4; #1;
    chk("raw_op_ready0", u_if.req0_ready_o, 1);
    @(negedge clk); v0 = 1'b0; #1;
    chk("raw_op_operator", u_if.alu_operator_o, 32'h5a);
    @(negedge clk); @(negedge clk); #1;
    chk("raw_op_target", u_if.resp0_target_o, 32'd7);
    chk("raw_op_cmp", u_if.resp0_cmp_o, 0);
    @(negedge clk);

    // Reset asserted during EXEC
    v0 = 1'b1; op0 = ALU_EQ; a0 = 32'd7; b0 = 32'd7; #1;
    chk("rmid_ready0", u_if.req0_ready_o, 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rmid_busy", busy_u, 0);
    chk("rmid_ready0_low", u_if.req0_ready_o, 0);
    chk("rmid_valid0", u_if.resp0_valid_o, 0);
    chk("rmid_operator", u_if.alu_operator_o, ALU_ADD);
    chk("rmid_operand_a", u_if.alu_operand_a_o, 0);
    chk("rmid_target", u_if.resp0_target_o, 0);
    chk("rmid_cmp", u_if.resp0_cmp_o, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rmid_release_ready0", u_if.req0_ready_o, 1);
    @(negedge clk); v0 = 1'b0; #1;
    chk("rmid_release_busy", busy_u, 1);
    chk("rmid_release_opa", u_if.alu_operand_a_o, 32'd7);
    @(negedge clk); @(negedge clk); #1;
    chk("rmid_resp_valid0", u_if.resp0_valid_o, 1);
    chk("rmid_resp_cmp", u_if.resp0_cmp_o, 1);
    chk("rmid_resp_target", u_if.resp0_target_o, 32'd14);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_branch_alu_arbiter.md
IBEX_BRANCH_ALU_ARBITER -- requirements
Module: ibex_branch_alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: RoundRobin, default 1, meaning 1 = round-robin grant and 0 = fixed priority to requester 0.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock.
REQ-003 The block SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port flush_i, input, 1, which aborts any in-flight operation.
REQ-005 For each requester n in {0,1}, the block SHALL have the following request ports:
- reqn_valid_i, input, 1, request valid.
- reqn_ready_o, output, 1, request accepted.
- reqn_op_i, input, ibex_pkg::alu_op_e, operation.
- reqn_a_i, input, 32, operand A.
- reqn_b_i, input, 32, operand B.
REQ-006 For each requester n in {0,1}, the block SHALL have the following response ports:
- respn_valid_o, output, 1, response valid.
- respn_ready_i, input, 1, response consumed.
- respn_target_o, output, 32, adder result.
- respn_cmp_o, output, 1, comparison result.
REQ-007 The block SHALL have the following ports to the shared branch ALU:
- alu_operator_o, output, ibex_pkg::alu_op_e.
- alu_operand_a_o, output, 32.
- alu_operand_b_o, output, 32.
- alu_adder_result_i, input, 32; the unit registers a+b, so this is valid one cycle after the operands are presented.
- alu_cmp_result_i, input, 1; combinational, valid in the same cycle as the operands.
REQ-008 The block SHALL have port busy_o, output, 1, asserted whenever the state is not IDLE.

Function
REQ-009 The FSM SHALL have the states IDLE, EXEC, WAIT and RESP.
REQ-010 In IDLE, at most one reqn_ready_o SHALL be high, and only to a requester whose valid is high. A handshake is valid&&ready in the same cycle.
REQ-011 Grant rule: if only one requester is valid, that requester wins. If both are valid, RoundRobin=1 grants the requester other than last_grant, and RoundRobin=0 grants requester 0.
REQ-012 last_grant SHALL update only on a handshake.
REQ-013 On a handshake, the op, A and B inputs SHALL be latched into held registers and the winner index latched into owner; the next state is EXEC.
REQ-014 alu_operator_o, alu_operand_a_o and alu_operand_b_o SHALL always be driven from the held registers.
REQ-015 EXEC SHALL capture alu_cmp_result_i into cmp_q; the next state is WAIT.
REQ-016 WAIT SHALL capture alu_adder_result_i into target_q; the next state is RESP.
REQ-017 In RESP, resp[owner]_valid_o SHALL be 1 and the other responder's valid SHALL be 0.
REQ-018 respn_target_o and respn_cmp_o SHALL equal target_q and cmp_q for both responders at all times.
REQ-019 The RESP exit condition SHALL be:
- RESP with resp[owner]_ready_i high SHALL go to IDLE.
- RESP with resp[owner]_ready_i low SHALL hold, with the response data stable.
REQ-020 Latency: if the handshake is in cycle T, respn_valid_o SHALL rise in cycle T+3. With a consumer that is always ready, throughput is one operation per 4 cycles.
REQ-021 No request SHALL be accepted outside IDLE, i.e. both ready outputs are 0.
REQ-022 A request that has been handshaken SHALL NOT change the held registers until the next IDLE handshake.
REQ-023 flush_i high in any state SHALL force IDLE at the next edge, suppress any pending response, and leave cmp_q and target_q unchanged.
REQ-024 flush_i high in IDLE SHALL force both ready outputs to 0 that cycle.
REQ-025 flush_i SHALL take priority over a simultaneous resp ready.
REQ-026 All operand and result arithmetic SHALL be 32-bit, with no width extension. Adder wrap-around (e.g. 0xFFFFFFFF+1=0) SHALL be passed through unchanged.
REQ-027 Operator values outside the branch/comparison set SHALL be forwarded unmodified; the block SHALL NOT decode them.

Reset
REQ-028 While rst_i is high, the block SHALL asynchronously enter the following reset state:
- state = IDLE, last_grant = 1 (so requester 0 wins the first tie).
- held operator = ALU_ADD, held operands = 0.
- cmp_q = 0, target_q = 0.
REQ-029 During reset, all ready and valid outputs SHALL be 0 and busy_o SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation without emitting a response. The first handshake after reset release SHALL be allowed in the first cycle rst_i is low.

Verification
REQ-031 Single requester: req0 issues ALU_EQ with A=B=0x10, resp0_ready_i held at 1 -> resp0_valid_o high exactly 3 cycles after the handshake, resp0_cmp_o=1, resp0_target_o=0x20.
REQ-032 Tie with RoundRobin=1: both requesters valid continuously -> grants alternate 0,1,0,1 starting with 0; with RoundRobin=0, every grant goes to requester 0.
REQ-033 Backpressure: resp1_ready_i held at 0 for 5 cycles in RESP -> resp1_valid_o held, data stable, both ready outputs 0; release -> IDLE next cycle.
REQ-034 Flush in WAIT: req1 ALU_LTU with A=1, B=2 accepted, flush_i pulsed during WAIT -> no resp1_valid_o, IDLE next cycle, busy_o=0.
REQ-035 Wrap-around: ALU_GEU with A=0xFFFFFFFF, B=1 -> target=0x00000000, cmp=1.
REQ-036 Reset mid-op: rst_i asserted during EXEC -> all outputs at reset values immediately; a new req0 accepted in the first cycle after release.
